// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch/load-store requesters, the arbiter and the shared 4096x24 memory.
// The slave modport is the arbiter's view; the master modport is the requester/memory side.
`ifndef HBIT_ADDR
`define HBIT_ADDR 11
`endif
`ifndef HBIT_DATA
`define HBIT_DATA 23
`endif

interface mem_arbiter_if;
  logic                  iw_a_req;
  logic [`HBIT_ADDR:0]   iw_a_addr;
  logic                  ow_a_gnt;
  logic                  or_a_rvalid;
  logic [`HBIT_DATA:0]   ow_a_rdata;

  logic                  iw_b_req;
  logic                  iw_b_we;
  logic                  iw_b_lock;
  logic [`HBIT_ADDR:0]   iw_b_addr;
  logic [`HBIT_DATA:0]   iw_b_wdata;
  logic                  ow_b_gnt;
  logic                  or_b_rvalid;
  logic [`HBIT_DATA:0]   ow_b_rdata;

  logic                  ow_mem_we;
  logic [`HBIT_ADDR:0]   ow_mem_addr;
  logic [`HBIT_DATA:0]   ow_mem_wdata;
  logic [`HBIT_DATA:0]   iw_mem_rdata;

  modport slave (
    input  iw_a_req, iw_a_addr,
    output ow_a_gnt, or_a_rvalid, ow_a_rdata,
    input  iw_b_req, iw_b_we, iw_b_lock, iw_b_addr, iw_b_wdata,
    output ow_b_gnt, or_b_rvalid, ow_b_rdata,
    output ow_mem_we, ow_mem_addr, ow_mem_wdata,
    input  iw_mem_rdata
  );

  modport master (
    output iw_a_req, iw_a_addr,
    input  ow_a_gnt, or_a_rvalid, ow_a_rdata,
    output iw_b_req, iw_b_we, iw_b_lock, iw_b_addr, iw_b_wdata,
    input  ow_b_gnt, or_b_rvalid, ow_b_rdata,
    input  ow_mem_we, ow_mem_addr, ow_mem_wdata,
    output iw_mem_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: fetch (A, read-only) vs load/store (B, read/write),
// with bounded starvation of B and a B lock for atomic read-modify-write.
`ifndef HBIT_ADDR
`define HBIT_ADDR 11
`endif
`ifndef HBIT_DATA
`define HBIT_DATA 23
`endif

module mem_arbiter #(
  parameter int unsigned MAX_WAIT = 3
) (
  input  logic           iw_clk,
  input  logic           iw_rst_n,
  mem_arbiter_if.slave   bus
);

  typedef enum logic {
    NORM = 1'b0,
    LOCK = 1'b1
  } state_t;

  localparam logic [3:0] WAIT_LIM = 4'(MAX_WAIT);

  state_t      r_state;
  logic [3:0]  r_b_wait;
  logic        w_a_gnt;
  logic        w_b_gnt;

  // B wins a contested cycle only once it has lost WAIT_LIM in a row; while locked A is shut out.
  always_comb begin
    w_a_gnt = 1'b0;
    w_b_gnt = 1'b0;
    if (r_state == LOCK) begin
      w_b_gnt = bus.iw_b_req;
    end else if (bus.iw_b_req && (!bus.iw_a_req || r_b_wait == WAIT_LIM)) begin
      w_b_gnt = 1'b1;
    end else begin
      w_a_gnt = bus.iw_a_req;
    end
    if (!iw_rst_n) begin
      w_a_gnt = 1'b0;
      w_b_gnt = 1'b0;
    end
  end

  assign bus.ow_a_gnt     = w_a_gnt;
  assign bus.ow_b_gnt     = w_b_gnt;
  assign bus.ow_mem_we    = w_b_gnt & bus.iw_b_we;
  assign bus.ow_mem_addr  = w_b_gnt ? bus.iw_b_addr : bus.iw_a_addr;
  assign bus.ow_mem_wdata = bus.iw_b_wdata;
  assign bus.ow_a_rdata   = bus.iw_mem_rdata;
  assign bus.ow_b_rdata   = bus.iw_mem_rdata;

  // The memory returns data one cycle after the access, so the read tags are simply the delayed grants.
  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      r_state         <= NORM;
      r_b_wait        <= 4'd0;
      bus.or_a_rvalid <= 1'b0;
      bus.or_b_rvalid <= 1'b0;
    end else begin
      bus.or_a_rvalid <= w_a_gnt;
      bus.or_b_rvalid <= w_b_gnt & ~bus.iw_b_we;

      if (!bus.iw_b_req || w_b_gnt) begin
        r_b_wait <= 4'd0;
      end else if (r_b_wait != WAIT_LIM) begin
        r_b_wait <= r_b_wait + 4'd1;
      end

      case (r_state)
        NORM: if (w_b_gnt && bus.iw_b_lock) r_state <= LOCK;
        LOCK: if (!bus.iw_b_req || !bus.iw_b_lock) r_state <= NORM;
        default: r_state <= NORM;
      endcase
    end
  end

endmodule
